// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared reorder buffer entry type, tag type and sizing constants
package Processor_Pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_PREG_W = 6;
  localparam int ROB_AREG_W = 5;

  typedef logic [ROB_TAG_W-1:0] ROB_Tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  dst_valid;
    logic [ROB_AREG_W-1:0] areg;
    logic [ROB_PREG_W-1:0] preg;
    logic [ROB_PREG_W-1:0] old_preg;
  } ROB_Entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - two-wide in-order retirement buffer with branch rollback
module reorder_buffer
  import Processor_Pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int PREG_W = ROB_PREG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          Alloc_Valid,
  input  logic [1:0]          Alloc_Dst_Valid,
  input  logic [9:0]          Alloc_Areg,
  input  logic [2*PREG_W-1:0] Alloc_Preg,
  input  logic [2*PREG_W-1:0] Alloc_Old_Preg,
  output logic [2*TAG_W-1:0]  Alloc_Tag,
  input  logic [1:0]          Cmpl_Valid,
  input  logic [2*TAG_W-1:0]  Cmpl_Tag,
  input  logic                Branch_Flush,
  input  logic [TAG_W-1:0]    Branch_Tag,
  output logic                Reorder_Buffer_Full,
  output logic                Reorder_Buffer_Empty,
  output logic [1:0]          Commit_Valid,
  output logic [1:0]          Commit_Dst_Valid,
  output logic [9:0]          Commit_Areg,
  output logic [2*PREG_W-1:0] Commit_Preg,
  output logic [2*PREG_W-1:0] Commit_Old_Preg,
  output logic                Commit
);

  // head/tail carry an extra wrap bit so count==DEPTH is distinguishable from empty
  logic [TAG_W:0]   head_q, head_d, tail_q, tail_d, count;
  ROB_Entry_t       rob_q [DEPTH];
  ROB_Entry_t       rob_d [DEPTH];
  logic [TAG_W-1:0] head_idx, head1_idx, tail_idx, tail1_idx;
  logic             commit0, commit1;
  logic [1:0]       alloc_n;

  assign count     = tail_q - head_q;
  assign head_idx  = head_q[TAG_W-1:0];
  assign head1_idx = head_idx + TAG_W'(1);
  assign tail_idx  = tail_q[TAG_W-1:0];
  assign tail1_idx = tail_idx + TAG_W'(1);

  assign Alloc_Tag            = {tail1_idx, tail_idx};
  assign Reorder_Buffer_Full  = (count >= (TAG_W+1)'(DEPTH-1));
  assign Reorder_Buffer_Empty = (count == '0);

  // Retirement looks only at registered state, so a completion never commits in its own cycle
  assign commit0 = rob_q[head_idx].valid && rob_q[head_idx].done;
  assign commit1 = commit0 && rob_q[head1_idx].valid && rob_q[head1_idx].done;

  assign Commit_Valid     = {commit1, commit0};
  assign Commit           = commit0;
  assign Commit_Dst_Valid = {rob_q[head1_idx].dst_valid, rob_q[head_idx].dst_valid};
  assign Commit_Areg      = {rob_q[head1_idx].areg, rob_q[head_idx].areg};
  assign Commit_Preg      = {rob_q[head1_idx].preg, rob_q[head_idx].preg};
  assign Commit_Old_Preg  = {rob_q[head1_idx].old_preg, rob_q[head_idx].old_preg};

  // Number of slots accepted this cycle; 2'b10 and any request while full or flushing are dropped
  always_comb begin
    alloc_n = 2'd0;
    if (!Reorder_Buffer_Full && !Branch_Flush) begin
      if (Alloc_Valid == 2'b11) begin
        alloc_n = 2'd2;
      end else if (Alloc_Valid == 2'b01) begin
        alloc_n = 2'd1;
      end
    end
  end

  // Pointer update: head advances by retired count, tail either grows or snaps back behind the branch
  always_comb begin
    head_d = head_q + {{(TAG_W-1){1'b0}}, commit1, commit0 & ~commit1};
    tail_d = tail_q + {{(TAG_W-1){1'b0}}, alloc_n};
    if (Branch_Flush) begin
      tail_d = head_d + {1'b0, Branch_Tag - head_d[TAG_W-1:0]} + (TAG_W+1)'(1);
    end
  end

  // Entry update in priority order: completion, flush squash, commit clear, then new allocations
  always_comb begin
    logic [TAG_W-1:0] br_off;
    logic [TAG_W-1:0] c_idx;
    br_off = Branch_Tag - head_idx;
    c_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rob_d[i] = rob_q[i];
    end
    for (int c = 0; c < 2; c++) begin
      c_idx = Cmpl_Tag[c*TAG_W +: TAG_W];
      if (Cmpl_Valid[c] && rob_q[c_idx].valid) begin
        rob_d[c_idx].done = 1'b1;
      end
    end
    if (Branch_Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((TAG_W'(i) - head_idx) > br_off) begin
          rob_d[i].valid = 1'b0;
          rob_d[i].done  = 1'b0;
        end
      end
    end
    if (commit0) begin
      rob_d[head_idx] = '0;
    end
    if (commit1) begin
      rob_d[head1_idx] = '0;
    end
    if (alloc_n != 2'd0) begin
      rob_d[tail_idx] = '{valid: 1'b1, done: 1'b0, dst_valid: Alloc_Dst_Valid[0],
                          areg: Alloc_Areg[4:0], preg: Alloc_Preg[PREG_W-1:0],
                          old_preg: Alloc_Old_Preg[PREG_W-1:0]};
    end
    if (alloc_n == 2'd2) begin
      rob_d[tail1_idx] = '{valid: 1'b1, done: 1'b0, dst_valid: Alloc_Dst_Valid[1],
                           areg: Alloc_Areg[9:5], preg: Alloc_Preg[2*PREG_W-1:PREG_W],
                           old_preg: Alloc_Old_Preg[2*PREG_W-1:PREG_W]};
    end
  end

  // State registers; reset discards every in-flight entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= rob_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed scoreboard bench for reorder_buffer
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PREG_W = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          Alloc_Valid;
  logic [1:0]          Alloc_Dst_Valid;
  logic [9:0]          Alloc_Areg;
  logic [2*PREG_W-1:0] Alloc_Preg;
  logic [2*PREG_W-1:0] Alloc_Old_Preg;
  logic [2*TAG_W-1:0]  Alloc_Tag;
  logic [1:0]          Cmpl_Valid;
  logic [2*TAG_W-1:0]  Cmpl_Tag;
  logic                Branch_Flush;
  logic [TAG_W-1:0]    Branch_Tag;
  logic                Reorder_Buffer_Full;
  logic                Reorder_Buffer_Empty;
  logic [1:0]          Commit_Valid;
  logic [1:0]          Commit_Dst_Valid;
  logic [9:0]          Commit_Areg;
  logic [2*PREG_W-1:0] Commit_Preg;
  logic [2*PREG_W-1:0] Commit_Old_Preg;
  logic                Commit;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst(rst),
    .Alloc_Valid(Alloc_Valid), .Alloc_Dst_Valid(Alloc_Dst_Valid), .Alloc_Areg(Alloc_Areg),
    .Alloc_Preg(Alloc_Preg), .Alloc_Old_Preg(Alloc_Old_Preg), .Alloc_Tag(Alloc_Tag),
    .Cmpl_Valid(Cmpl_Valid), .Cmpl_Tag(Cmpl_Tag),
    .Branch_Flush(Branch_Flush), .Branch_Tag(Branch_Tag),
    .Reorder_Buffer_Full(Reorder_Buffer_Full), .Reorder_Buffer_Empty(Reorder_Buffer_Empty),
    .Commit_Valid(Commit_Valid), .Commit_Dst_Valid(Commit_Dst_Valid), .Commit_Areg(Commit_Areg),
    .Commit_Preg(Commit_Preg), .Commit_Old_Preg(Commit_Old_Preg), .Commit(Commit)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  int         seq = 0;
  int         mon_e;
  logic [3:0] btail;
  logic [3:0] base;
  int         perm[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every retiring slot must match the oldest outstanding allocation
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        if (Commit_Valid[s]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: slot %0d retired with nothing expected at %0t", s, $time);
          end else begin
            mon_e = exp_q.pop_front();
            chk("commit_old_preg", 32'(Commit_Old_Preg[s*6 +: 6]), 32'(mon_e % 64));
            chk("commit_preg", 32'(Commit_Preg[s*6 +: 6]), 32'((mon_e + 17) % 64));
            chk("commit_areg", 32'(Commit_Areg[s*5 +: 5]), 32'(mon_e % 32));
            chk("commit_dst_valid", 32'(Commit_Dst_Valid[s]), 32'(mon_e % 2));
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    Alloc_Valid = '0; Alloc_Dst_Valid = '0; Alloc_Areg = '0; Alloc_Preg = '0; Alloc_Old_Preg = '0;
    Cmpl_Valid = '0; Cmpl_Tag = '0; Branch_Flush = 1'b0; Branch_Tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_slot(input int s);
    Alloc_Dst_Valid[s]        = 1'(seq % 2);
    Alloc_Areg[s*5 +: 5]      = 5'(seq % 32);
    Alloc_Preg[s*6 +: 6]      = 6'((seq + 17) % 64);
    Alloc_Old_Preg[s*6 +: 6]  = 6'(seq % 64);
    exp_q.push_back(seq);
    seq++;
  endtask

  task automatic alloc2();
    chk("alloc_tag", 32'(Alloc_Tag), 32'({btail + 4'd1, btail}));
    Alloc_Valid = 2'b11;
    set_slot(0);
    set_slot(1);
    btail = btail + 4'd2;
  endtask

  task automatic cmpl(input int port, input logic [3:0] t);
    Cmpl_Valid[port]       = 1'b1;
    Cmpl_Tag[port*4 +: 4]  = t;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(Reorder_Buffer_Empty), 32'd1);
    chk({tag, "_full"}, 32'(Reorder_Buffer_Full), 32'd0);
    chk({tag, "_commit"}, 32'(Commit), 32'd0);
    chk({tag, "_commit_valid"}, 32'(Commit_Valid), 32'd0);
    chk({tag, "_alloc_tag"}, 32'(Alloc_Tag), 32'h10);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    exp_q.delete();
    btail = 4'd0;
    #3 rst = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!Reorder_Buffer_Empty && n < budget) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(Reorder_Buffer_Empty), 32'd1);
    chk("drain_scoreboard_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    btail = 4'd0;
    rst = 1'b1;
    #7;
    check_reset_state("reset");
    rst = 1'b0;
    step();

    // Fill: eight double allocations with no completion
    for (int k = 0; k < 7; k++) begin
      alloc2();
      step();
    end
    chk("full_at_14", 32'(Reorder_Buffer_Full), 32'd0);
    alloc2();
    step();
    chk("full_at_16", 32'(Reorder_Buffer_Full), 32'd1);
    chk("empty_at_16", 32'(Reorder_Buffer_Empty), 32'd0);
    Alloc_Valid = 2'b11;
    step();
    chk("drop_while_full_tag", 32'(Alloc_Tag), 32'({btail + 4'd1, btail}));
    chk("still_full", 32'(Reorder_Buffer_Full), 32'd1);
    for (int k = 0; k < 8; k++) begin
      cmpl(0, 4'(2*k));
      cmpl(1, 4'(2*k + 1));
      step();
    end
    wait_empty(20);

    // Illegal 2'b10 pattern is ignored; single-slot allocation then mid-traffic reset
    Alloc_Valid = 2'b10;
    step();
    chk("ignore_10_tag", 32'(Alloc_Tag), 32'({btail + 4'd1, btail}));
    chk("ignore_10_empty", 32'(Reorder_Buffer_Empty), 32'd1);
    Alloc_Valid = 2'b01;
    set_slot(0);
    btail = btail + 4'd1;
    step();
    chk("single_alloc_tag", 32'(Alloc_Tag), 32'({btail + 4'd1, btail}));
    alloc2();
    step();
    do_reset();
    step();

    // Out-of-order completion: 3,2,1 then 0
    alloc2(); step();
    alloc2(); step();
    cmpl(0, 4'd3); step();
    cmpl(1, 4'd2); step();
    cmpl(0, 4'd1); step();
    chk("ooo_no_commit", 32'(Commit_Valid), 32'd0);
    cmpl(0, 4'd0); step();
    chk("ooo_commit_01", 32'(Commit_Valid), 32'b11);
    chk("ooo_commit_sig", 32'(Commit), 32'd1);
    step();
    chk("ooo_commit_23", 32'(Commit_Valid), 32'b11);
    step();
    chk("ooo_empty", 32'(Reorder_Buffer_Empty), 32'd1);
    chk("ooo_idle", 32'(Commit_Valid), 32'd0);

    // Flush: branch at tag 2 while tag 0 retires
    do_reset();
    step();
    alloc2(); step();
    alloc2(); step();
    alloc2(); step();
    cmpl(0, 4'd0); step();
    chk("flush_cycle_commit", 32'(Commit_Valid), 32'b01);
    Branch_Flush = 1'b1;
    Branch_Tag   = 4'd2;
    Alloc_Valid  = 2'b11;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    btail = 4'd3;
    step();
    chk("flush_tail", 32'(Alloc_Tag), 32'h43);
    chk("flush_not_empty", 32'(Reorder_Buffer_Empty), 32'd0);
    cmpl(0, 4'd4); step();
    chk("flush_stale_none", 32'(Commit_Valid), 32'd0);
    cmpl(0, 4'd1); cmpl(1, 4'd2); step();
    chk("flush_survivors", 32'(Commit_Valid), 32'b11);
    step();
    chk("flush_empty", 32'(Reorder_Buffer_Empty), 32'd1);
    alloc2(); step();
    cmpl(0, 4'd3); step();
    chk("stale_cmpl_ignored", 32'(Commit_Valid), 32'b01);
    cmpl(0, 4'd4); step();
    wait_empty(10);

    // Simultaneous: double completion of one tag, alloc and commit in one cycle
    alloc2(); step();
    cmpl(0, btail - 4'd2); step();
    chk("sim_pre_commit", 32'(Commit_Valid), 32'b01);
    cmpl(0, btail - 4'd1);
    cmpl(1, btail - 4'd1);
    alloc2();
    step();
    chk("sim_commit", 32'(Commit_Valid), 32'b01);
    chk("sim_tail", 32'(Alloc_Tag), 32'({btail + 4'd1, btail}));
    chk("sim_full", 32'(Reorder_Buffer_Full), 32'd0);
    step();
    chk("sim_wait", 32'(Commit_Valid), 32'd0);
    cmpl(0, btail - 4'd2); cmpl(1, btail - 4'd1); step();
    wait_empty(10);

    // Wrap: 40 instructions in groups of 8 with shuffled completion order
    for (int g = 0; g < 5; g++) begin
      base = btail;
      for (int k = 0; k < 4; k++) begin
        alloc2();
        step();
      end
      for (int j = 0; j < 8; j++) perm[j] = j;
      for (int j = 7; j > 0; j--) begin
        int r;
        int tmp;
        r = $urandom_range(0, j);
        tmp = perm[j]; perm[j] = perm[r]; perm[r] = tmp;
      end
      for (int j = 0; j < 8; j++) begin
        cmpl($urandom_range(0, 1), base + 4'(perm[j]));
        step();
      end
      wait_empty(20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
